// File: rtl/main_bus_mem_responder_pkg.sv
// Shared constants and FSM state type for the main-bus memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package main_bus_pkg;

  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_BYTES     = 64;
  localparam int TAG_WRITE_BIT  = 12;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_BEAT,
    WR_DATA
  } resp_state_t;

  // Tag bit 12 marks a line write; clear means line read.
  function automatic logic is_write_tag(input logic [TAG_WRITE_BIT:0] tag);
    return tag[TAG_WRITE_BIT];
  endfunction

endpackage

// File: rtl/main_bus_mem_responder_store.sv
// Line store: LINES x BEATS words, one write port and one combinational read port.
// Latency: write lands on the clock edge; read data is combinational.
// Backpressure: none; caller qualifies the write enable.
module mem_resp_store
  import main_bus_pkg::*;
#(
  parameter int LINES  = 1024,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(LINES),
  parameter int BEAT_W = $clog2(BEATS_PER_LINE)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic [DATA_W-1:0] rd_dat
);

  // Contents survive reset on purpose: the store models backing memory.
  logic [DATA_W-1:0] mem [LINES*BEATS_PER_LINE];

  // Single write port, one 64-bit beat per cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_idx, wr_beat}] <= wr_dat;
    end
  end

  assign rd_dat = mem[{rd_idx, rd_beat}];

endmodule

// File: rtl/main_bus_mem_responder.sv
// Main-bus memory responder: serves 8-beat line reads and absorbs 8-beat line writes.
// Latency: first read beat RD_LATENCY cycles after address accept; writes land per beat.
// Backpressure: read beats hold until bus_respack; requests stall (reqack=0) while a read is in flight.
// Optional: define MEM_RESP_STALL_EN to insert a one-cycle gap after every non-final read beat.
module main_bus_mem_responder
  import main_bus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_LINES      = 1024,
  parameter int RD_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int IDX_W    = $clog2(MEM_LINES);
  localparam int BEAT_W   = $clog2(BEATS_PER_LINE);
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

  resp_state_t               state, state_nxt;
  logic [BEAT_W-1:0]         beat;
  logic [LAT_W-1:0]          lat_cnt;
  logic [IDX_W-1:0]          idx;
  logic [BUS_TAG_WIDTH-1:0]  tag;
  logic                      gap;
  logic                      req_xfer, resp_xfer, last_beat, wr_en;
  logic [BUS_DATA_WIDTH-1:0] rd_dat;

  assign req_xfer  = bus_reqcyc && bus_reqack;
  assign resp_xfer = bus_respcyc && bus_respack;
  assign last_beat = (beat == LAST_BEAT);
  assign wr_en     = (state == WR_DATA) && req_xfer;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. The wait counter holds the cycles left before the first beat,
  // so RD_WAIT is left when it reaches 1 (giving exactly RD_LATENCY cycles overall).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_xfer) begin
          if (is_write_tag(bus_reqtag[TAG_WRITE_BIT:0])) state_nxt = WR_DATA;
          else if (RD_LATENCY == 1)                      state_nxt = RD_BEAT;
          else                                           state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: if (lat_cnt <= LAT_W'(1))     state_nxt = RD_BEAT;
      RD_BEAT: if (resp_xfer && last_beat)   state_nxt = IDLE;
      WR_DATA: if (req_xfer && last_beat)    state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Capture address/tag, run the wait counter and the beat counter, track stall gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat    <= '0;
      lat_cnt <= '0;
      idx     <= '0;
      tag     <= '0;
      gap     <= 1'b0;
    end else begin
      if (state == IDLE && req_xfer) begin
        idx     <= bus_req[OFFSET_W +: IDX_W];
        tag     <= bus_reqtag;
        beat    <= '0;
        lat_cnt <= LAT_LOAD;
      end
      if (state == RD_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      // The beat counter wraps to 0 after the final beat, ready for the next line.
      if (wr_en || resp_xfer) begin
        beat <= beat + BEAT_W'(1);
      end
`ifdef MEM_RESP_STALL_EN
      gap <= resp_xfer && !last_beat;
`else
      gap <= 1'b0;
`endif
    end
  end

  // Outputs: accept only when idle or absorbing write data; response fields are zero when not valid.
  always_comb begin
    bus_reqack  = bus_reqcyc && (state == IDLE || state == WR_DATA);
    bus_respcyc = (state == RD_BEAT) && !gap;
    bus_resp    = bus_respcyc ? rd_dat : '0;
    bus_resptag = bus_respcyc ? tag : '0;
  end

  mem_resp_store #(
    .LINES  (MEM_LINES),
    .DATA_W (BUS_DATA_WIDTH)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_beat (beat),
    .wr_dat  (bus_req),
    .rd_idx  (idx),
    .rd_beat (beat),
    .rd_dat  (rd_dat)
  );

endmodule

// File: tb/tb_main_bus_mem_responder.sv
// Scoreboard bench for main_bus_mem_responder: directed line reads/writes, backpressure, stall, wrap, reset.
// Latency: checks first read beat lands RD_LATENCY cycles after the address accept.
// Backpressure: drives bus_respack low mid-line and checks the held beat stays stable.
module tb_main_bus_mem_responder;

  localparam int MEM_LINES = 1024;
  localparam int RD_LAT    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;

  int n_checks    = 0;
  int n_pass      = 0;
  int resp_cycles = 0;

  logic [76:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [12:0] hold_tag  = '0;
  logic [63:0] hold_dat  = '0;

  always #5 clk = ~clk;

  main_bus_mem_responder #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .MEM_LINES      (MEM_LINES),
    .RD_LATENCY     (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endfunction

  // Monitor: pops the scoreboard on every accepted response beat and checks held beats.
  always @(negedge clk) begin
    if (hold_prev)
      chk("hold_stable", 96'({bus_respcyc, bus_resptag, bus_resp}), 96'({1'b1, hold_tag, hold_dat}));
    if (bus_respcyc) resp_cycles++;
    if (bus_respcyc && bus_respack) begin
      chk("beat_expected", 96'(exp_q.size() != 0), 96'(1));
      if (exp_q.size() != 0) chk("resp_beat", 96'({bus_resptag, bus_resp}), 96'(exp_q.pop_front()));
    end
    hold_prev = bus_respcyc && !bus_respack;
    hold_tag  = bus_resptag;
    hold_dat  = bus_resp;
  end

  // Present one request beat from posedge+1 until accepted; waited = extra cycles needed.
  task automatic send_beat(input logic [63:0] d, input logic [12:0] t, output int waited);
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = t;
    waited     = 0;
    @(negedge clk);
    while (!bus_reqack && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1;
    bus_reqcyc = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base,
                          input string nm);
    int w;
    int acks;
    int c0;
    acks = 0;
    c0   = resp_cycles;
    send_beat(addr, tag, w);
    if (w == 0) acks++;
    for (int i = 0; i < 8; i++) begin
      send_beat(base + 64'(i), 13'h0AA, w);
      if (w == 0) acks++;
    end
    repeat (2) @(negedge clk);
    chk({nm, "_acks"}, 96'(acks), 96'(9));
    chk({nm, "_no_resp"}, 96'(resp_cycles - c0), 96'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base,
                         input int stall_beat, input int stall_len, input string nm);
    int n;
    int c0;
    int g;
    for (int i = 0; i < 8; i++) exp_q.push_back({tag, base + 64'(i)});
    c0 = resp_cycles;
    send_beat(addr, tag, n);
    chk({nm, "_addr_ack"}, 96'(n), 96'(0));
    n = 1;
    @(negedge clk);
    while (!bus_respcyc && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 96'(n), 96'(RD_LAT));
    if (stall_beat >= 0) begin
      repeat (stall_beat) @(posedge clk);
      #1 bus_respack = 1'b0;
      repeat (stall_len) @(posedge clk);
      #1 bus_respack = 1'b1;
    end
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk({nm, "_drain"}, 96'(exp_q.size()), 96'(0));
    chk({nm, "_resp_cycles"}, 96'(resp_cycles - c0), 96'(8 + ((stall_beat >= 0) ? stall_len : 0)));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int g;
    int c0;
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reqack",  96'(bus_reqack),  96'(0));
    chk("rst_respcyc", 96'(bus_respcyc), 96'(0));
    chk("rst_resp",    96'(bus_resp),    96'(0));
    chk("rst_resptag", 96'(bus_resptag), 96'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload line 5, then read it back: beats 0x50..0x57, tag 0x0A3.
    do_write(64'h140, 13'h1000, 64'h50, "wr_line5");
    do_read(64'h140, 13'h0A3, 64'h50, -1, 0, "rd_line5");

    // Write line 7 and read it back; offset bits of the read address are ignored.
    do_write(64'h1C0, 13'h1001, 64'hA0, "wr_line7");
    do_read(64'h1C0, 13'h0B1, 64'hA0, -1, 0, "rd_line7");
    do_read(64'h17F, 13'h0B2, 64'h50, -1, 0, "rd_offset");

    // Backpressure: hold beat 3 for three cycles.
    do_read(64'h140, 13'h0C2, 64'h50, 3, 3, "rd_bp");

    // Wrap: address beyond MEM_LINES lands on line 1.
    do_write(64'(MEM_LINES * 64 + 64'h40), 13'h1002, 64'hC0, "wr_wrap");
    do_read(64'h40, 13'h0C3, 64'hC0, -1, 0, "rd_wrap");

    // Request during a read response stalls until the cycle after beat 7.
    c0 = resp_cycles;
    for (int i = 0; i < 8; i++) exp_q.push_back({13'h0E1, 64'hA0 + 64'(i)});
    send_beat(64'h1C0, 13'h0E1, n);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) exp_q.push_back({13'h0E2, 64'hC0 + 64'(i)});
    bus_reqcyc = 1'b1;
    bus_req    = 64'h40;
    bus_reqtag = 13'h0E2;
    n = 6;
    @(negedge clk);
    while (!bus_reqack && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("stall_req_ack_cycle", 96'(n), 96'(12));
    @(posedge clk); #1;
    bus_reqcyc = 1'b0;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("stall_drain", 96'(exp_q.size()), 96'(0));
    chk("stall_resp_cycles", 96'(resp_cycles - c0), 96'(16));
    @(posedge clk); #1;

    // Reset at beat 2: beats 0..2 transfer, nothing after; then a fresh read works.
    for (int i = 0; i < 3; i++) exp_q.push_back({13'h0D4, 64'hA0 + 64'(i)});
    send_beat(64'h1C0, 13'h0D4, n);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_respcyc", 96'(bus_respcyc), 96'(0));
    chk("midrst_reqack",  96'(bus_reqack),  96'(0));
    repeat (3) @(negedge clk);
    chk("midrst_respcyc_idle", 96'(bus_respcyc), 96'(0));
    chk("midrst_drain", 96'(exp_q.size()), 96'(0));
    @(posedge clk); #1;
    do_read(64'h1C0, 13'h0D5, 64'hA0, -1, 0, "rd_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
